// File: rtl/fcs_pkg.sv
// Shared definitions for the frame capture scheduler: FSM encoding and error codes.
package fcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } fcs_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LINES   = 2'b10;

endpackage

// File: rtl/frame_capture_sched_edge_sync.sv
// Two-flop synchroniser for an asynchronous camera strobe, followed by a
// rising-edge detector producing a single-cycle pulse in the clk domain.
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Pulse is consumed by downstream logic on the third clk edge after din rises.
    assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/frame_capture_sched.sv
// Sequences one camera frame capture per host request: frame skipping, a
// one-frame capture window with line counting, and a watchdog for stalled sensors.
module frame_capture_sched
    import fcs_pkg::*;
#(
    parameter int SKIP_W    = 4,
    parameter int LINE_W    = 10,
    parameter int EXP_LINES = 480,
    parameter int TMO_W     = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic              start,
    input  logic [SKIP_W-1:0] skip_frames,
    output logic              busy,
    output logic              frame_en,
    output logic [LINE_W-1:0] line_cnt,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam logic [LINE_W-1:0] LINE_MAX  = {LINE_W{1'b1}};
    localparam logic [LINE_W-1:0] EXP_CNT   = LINE_W'(EXP_LINES);
    localparam logic [TMO_W-1:0]  WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic v_rise;
    logic h_rise;

    edge_sync u_vsync_sync (
        .clk   (clk),
        .reset (reset),
        .din   (vsync),
        .rise  (v_rise)
    );

    edge_sync u_href_sync (
        .clk   (clk),
        .reset (reset),
        .din   (href),
        .rise  (h_rise)
    );

    fcs_state_t        state_q,    state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
    logic [TMO_W-1:0]  wdog_q,     wdog_d;
    logic              error_q,    error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              done_q,     done_d;
    logic              frame_en_q, frame_en_d;
    logic              busy_q,     busy_d;
    logic              timeout;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        line_cnt_d = line_cnt_q;
        wdog_d     = wdog_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        timeout    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ARM;
                    skip_cnt_d = skip_frames;
                    line_cnt_d = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    wdog_d     = '0;
                end
            end
            ST_ARM, ST_CAPTURE: begin
                // A vsync edge always wins over the watchdog terminal count.
                if (v_rise) begin
                    wdog_d = '0;
                    if (state_q == ST_ARM) begin
                        if (skip_cnt_q == '0) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            skip_cnt_d = skip_cnt_q - SKIP_W'(1);
                        end
                    end else begin
                        state_d = ST_DONE;
                        if (line_cnt_q != EXP_CNT) begin
                            error_d    = 1'b1;
                            err_code_d = ERR_LINES;
                        end
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    timeout    = 1'b1;
                    state_d    = ST_IDLE;
                    wdog_d     = '0;
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    wdog_d = wdog_q + TMO_W'(1);
                    if (state_q == ST_CAPTURE && h_rise && line_cnt_q != LINE_MAX) begin
                        line_cnt_d = line_cnt_q + LINE_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d     = (state_d == ST_DONE) || timeout;
        frame_en_d = (state_d == ST_CAPTURE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
            line_cnt_q <= '0;
            wdog_q     <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            done_q     <= 1'b0;
            frame_en_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            line_cnt_q <= line_cnt_d;
            wdog_q     <= wdog_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
            frame_en_q <= frame_en_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign frame_en = frame_en_q;
    assign line_cnt = line_cnt_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_frame_capture_sched.sv
// Directed bench for frame_capture_sched: one task per scenario, inline checks.
module tb_frame_capture_sched;

    logic       clk;
    logic       reset;
    logic       vsync;
    logic       href;
    logic       start;
    logic       start_t;
    logic [3:0] skip_frames;

    logic       busy, frame_en, done, error;
    logic [9:0] line_cnt;
    logic [1:0] err_code;

    logic       busy_t, frame_en_t, done_t, error_t;
    logic [9:0] line_cnt_t;
    logic [1:0] err_code_t;

    int n_checks = 0;
    int n_fail   = 0;

    frame_capture_sched #(.SKIP_W(4), .LINE_W(10), .EXP_LINES(480), .TMO_W(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .start       (start),
        .skip_frames (skip_frames),
        .busy        (busy),
        .frame_en    (frame_en),
        .line_cnt    (line_cnt),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    frame_capture_sched #(.SKIP_W(4), .LINE_W(10), .EXP_LINES(480), .TMO_W(8)) dut_tmo (
        .clk         (clk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .start       (start_t),
        .skip_frames (skip_frames),
        .busy        (busy_t),
        .frame_en    (frame_en_t),
        .line_cnt    (line_cnt_t),
        .done        (done_t),
        .error       (error_t),
        .err_code    (err_code_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        vsync = 1'b0;
        href  = 1'b0;
        start = 1'b0;
        start_t = 1'b0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic start_pulse(input logic [3:0] skip);
        skip_frames = skip;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic href_pulses(input int n);
        repeat (n) begin
            href = 1'b1;
            cyc(2);
            href = 1'b0;
            cyc(2);
        end
    endtask

    // Opens the capture window with a vsync pulse, checking frame_en rise timing.
    task automatic open_frame(input string tag);
        vsync = 1'b1;
        cyc(2);
        n_checks++;
        if (frame_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_fe_early: frame_en=%0b expected 0", tag, frame_en);
        end
        cyc(1);
        n_checks++;
        if (frame_en !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_fe_rise: frame_en=%0b expected 1", tag, frame_en);
        end
        cyc(1);
        vsync = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({busy, frame_en, done, error, err_code, line_cnt} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%0b fe=%0b done=%0b err=%0b code=%0d lines=%0d expected all 0",
                     busy, frame_en, done, error, err_code, line_cnt);
        end
        n_checks++;
        if ({busy_t, frame_en_t, done_t, error_t, err_code_t, line_cnt_t} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs_tmo: expected all 0, got busy=%0b done=%0b", busy_t, done_t);
        end
    endtask

    task automatic test_reset_mid_capture();
        apply_reset();
        start_pulse(4'd0);
        open_frame("rstcap");
        href_pulses(3);
        n_checks++;
        if (line_cnt !== 10'd3 || frame_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rstcap_pre: line_cnt=%0d fe=%0b expected 3 and 1", line_cnt, frame_en);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, frame_en, done, error, line_cnt} !== 14'h0) begin
            n_fail++;
            $display("FAIL rstcap_async: busy=%0b fe=%0b done=%0b err=%0b lines=%0d expected all 0",
                     busy, frame_en, done, error, line_cnt);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_capture_basic();
        apply_reset();
        start_pulse(4'd0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: busy=%0b expected 1", busy);
        end
        open_frame("basic");
        href_pulses(480);
        vsync = 1'b1;
        cyc(2);
        n_checks++;
        if (frame_en !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pre_end: fe=%0b done=%0b expected 1 and 0", frame_en, done);
        end
        cyc(1);
        n_checks++;
        if (done !== 1'b1 || frame_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: done=%0b fe=%0b busy=%0b expected 1 0 1", done, frame_en, busy);
        end
        n_checks++;
        if (line_cnt !== 10'd480 || error !== 1'b0 || err_code !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_result: lines=%0d err=%0b code=%0d expected 480 0 0", line_cnt, error, err_code);
        end
        cyc(1);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: done=%0b busy=%0b expected 0 0", done, busy);
        end
        vsync = 1'b0;
        cyc(4);
    endtask

    task automatic test_skip_frames();
        apply_reset();
        start_pulse(4'd2);
        for (int f = 0; f < 2; f++) begin
            vsync = 1'b1;
            cyc(3);
            n_checks++;
            if (frame_en !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL skip_frame%0d: fe=%0b busy=%0b expected 0 1", f, frame_en, busy);
            end
            vsync = 1'b0;
            cyc(2);
            href_pulses(5);
            n_checks++;
            if (line_cnt !== 10'd0) begin
                n_fail++;
                $display("FAIL skip_lines%0d: lines=%0d expected 0", f, line_cnt);
            end
        end
        open_frame("skip");
        href_pulses(480);
        vsync = 1'b1;
        cyc(3);
        n_checks++;
        if (done !== 1'b1 || line_cnt !== 10'd480 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL skip_result: done=%0b lines=%0d err=%0b expected 1 480 0", done, line_cnt, error);
        end
        vsync = 1'b0;
        cyc(4);
    endtask

    task automatic test_line_mismatch();
        apply_reset();
        start_pulse(4'd0);
        open_frame("short");
        href_pulses(479);
        vsync = 1'b1;
        cyc(3);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b1 || err_code !== 2'b10 || line_cnt !== 10'd479) begin
            n_fail++;
            $display("FAIL short_result: done=%0b err=%0b code=%0d lines=%0d expected 1 1 2 479",
                     done, error, err_code, line_cnt);
        end
        vsync = 1'b0;
        cyc(4);
        n_checks++;
        if (error !== 1'b1 || line_cnt !== 10'd479 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL short_sticky: err=%0b lines=%0d busy=%0b expected 1 479 0", error, line_cnt, busy);
        end
        start_pulse(4'd0);
        n_checks++;
        if (error !== 1'b0 || err_code !== 2'b00 || line_cnt !== 10'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL short_clear: err=%0b code=%0d lines=%0d busy=%0b expected 0 0 0 1",
                     error, err_code, line_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        start_pulse(4'd0);
        open_frame("b2b");
        href_pulses(240);
        start_pulse(4'd3);
        n_checks++;
        if (busy !== 1'b1 || frame_en !== 1'b1 || line_cnt !== 10'd240) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%0b fe=%0b lines=%0d expected 1 1 240", busy, frame_en, line_cnt);
        end
        href_pulses(240);
        vsync = 1'b1;
        href  = 1'b1;
        cyc(3);
        n_checks++;
        if (done !== 1'b1 || line_cnt !== 10'd480 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_result: done=%0b lines=%0d err=%0b expected 1 480 0", done, line_cnt, error);
        end
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        cyc(4);
        n_checks++;
        if (busy !== 1'b0 || frame_en !== 1'b0 || line_cnt !== 10'd480) begin
            n_fail++;
            $display("FAIL b2b_idle: busy=%0b fe=%0b lines=%0d expected 0 0 480", busy, frame_en, line_cnt);
        end
    endtask

    task automatic test_watchdog();
        int cnt;
        apply_reset();
        skip_frames = 4'd0;
        start_t = 1'b1;
        cyc(1);
        start_t = 1'b0;
        cnt = 0;
        while (done_t !== 1'b1 && cnt < 400) begin
            cyc(1);
            cnt++;
        end
        n_checks++;
        if (cnt !== 255) begin
            n_fail++;
            $display("FAIL tmo_latency: done after %0d cycles, expected 255", cnt);
        end
        n_checks++;
        if (error_t !== 1'b1 || err_code_t !== 2'b01 || busy_t !== 1'b0 || frame_en_t !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_result: err=%0b code=%0d busy=%0b fe=%0b expected 1 1 0 0",
                     error_t, err_code_t, busy_t, frame_en_t);
        end
        cyc(1);
        n_checks++;
        if (done_t !== 1'b0 || line_cnt_t !== 10'd0) begin
            n_fail++;
            $display("FAIL tmo_pulse: done=%0b lines=%0d expected 0 0", done_t, line_cnt_t);
        end
    endtask

    initial begin
        reset       = 1'b1;
        vsync       = 1'b0;
        href        = 1'b0;
        start       = 1'b0;
        start_t     = 1'b0;
        skip_frames = 4'd0;
        test_reset();
        test_reset_mid_capture();
        test_capture_basic();
        test_skip_frames();
        test_line_mismatch();
        test_back_to_back();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
